// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IFU and the LSU: fixed LSU priority with an IFU starvation guard.
// Optional WAIT-state timeout is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic              ifu_rsp_err,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic              lsu_rsp_err,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  stateT            state;
  logic             ownerIfu;
  logic [CNT_W-1:0] starveCnt;
  logic             starveHit;
  logic             grantLsu;
  logic             grantIfu;
  logic             timedOut;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] waitCnt;
  logic            ifuRspErrQ;
  logic            lsuRspErrQ;

  assign timedOut    = (waitCnt == TO_LAST);
  assign ifu_rsp_err = ifuRspErrQ;
  assign lsu_rsp_err = lsuRspErrQ;
`else
  assign timedOut    = 1'b0;
  assign ifu_rsp_err = 1'b0;
  assign lsu_rsp_err = 1'b0;
`endif

  // The IFU overrides LSU priority only once the LSU has won STARVE_LIMIT times in a row while the IFU waited.
  always_comb begin
    starveHit = (STARVE_LIMIT != 0) && ifu_req_valid && (starveCnt == STARVE_MAX);
    grantLsu  = !rst && (state == IDLE) && lsu_req_valid && !starveHit;
    grantIfu  = !rst && (state == IDLE) && ifu_req_valid && !grantLsu;
  end

  assign lsu_req_ready = grantLsu;
  assign ifu_req_ready = grantIfu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ownerIfu      <= 1'b0;
      starveCnt     <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= 8'h00;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      waitCnt       <= '0;
      ifuRspErrQ    <= 1'b0;
      lsuRspErrQ    <= 1'b0;
`endif
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      ifuRspErrQ    <= 1'b0;
      lsuRspErrQ    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grantLsu) begin
            ownerIfu      <= 1'b0;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
            if (ifu_req_valid && (starveCnt != STARVE_MAX))
              starveCnt <= starveCnt + CNT_W'(1);
          end else if (grantIfu) begin
            ownerIfu      <= 1'b1;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= 8'h00;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
            starveCnt     <= '0;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            waitCnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (ownerIfu) ifu_rdata <= mem_rdata;
            else          lsu_rdata <= mem_rdata;
            ifu_rsp_valid <= ownerIfu;
            lsu_rsp_valid <= !ownerIfu;
            state         <= RESP;
          end else if (timedOut) begin
            // A timed-out transaction still answers its owner, flagged as an error with zeroed data.
            if (ownerIfu) ifu_rdata <= '0;
            else          lsu_rdata <= '0;
            ifu_rsp_valid <= ownerIfu;
            lsu_rsp_valid <= !ownerIfu;
`ifdef MEM_ARB_TIMEOUT_EN
            ifuRspErrQ    <= ownerIfu;
            lsuRspErrQ    <= !ownerIfu;
`endif
            state         <= RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else begin
            waitCnt <= waitCnt + TO_W'(1);
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios and a randomized phase checked
// against a transaction-level model of the arbitration and response rules.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LIM = 4;
  localparam int TO  = 8;

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic          ifuReqValid = 1'b0;
  logic          lsuReqValid = 1'b0;
  logic          lsuWen      = 1'b0;
  logic          memReqReady = 1'b0;
  logic          memRspValid = 1'b0;
  logic [AW-1:0] ifuAddr     = '0;
  logic [AW-1:0] lsuAddr     = '0;
  logic [DW-1:0] lsuWdata    = '0;
  logic [DW-1:0] memRdata    = '0;
  logic [7:0]    lsuWmask    = 8'h00;

  logic          ifuReqReady, ifuRspValid, ifuRspErr, lsuReqReady, lsuRspValid, lsuRspErr;
  logic          memReqValid, memWen;
  logic [DW-1:0] ifuRdata, lsuRdata, memWdata;
  logic [AW-1:0] memAddr;
  logic [7:0]    memWmask;

  logic          nIfuReqReady, nIfuRspValid, nIfuRspErr, nLsuReqReady, nLsuRspValid, nLsuRspErr;
  logic          nMemReqValid, nMemWen;
  logic [DW-1:0] nIfuRdata, nLsuRdata, nMemWdata;
  logic [AW-1:0] nMemAddr;
  logic [7:0]    nMemWmask;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifuReqValid), .ifu_req_ready(ifuReqReady), .ifu_addr(ifuAddr),
    .ifu_rsp_valid(ifuRspValid), .ifu_rsp_err(ifuRspErr), .ifu_rdata(ifuRdata),
    .lsu_req_valid(lsuReqValid), .lsu_req_ready(lsuReqReady), .lsu_addr(lsuAddr),
    .lsu_wen(lsuWen), .lsu_wdata(lsuWdata), .lsu_wmask(lsuWmask),
    .lsu_rsp_valid(lsuRspValid), .lsu_rsp_err(lsuRspErr), .lsu_rdata(lsuRdata),
    .mem_req_valid(memReqValid), .mem_req_ready(memReqReady), .mem_addr(memAddr),
    .mem_wen(memWen), .mem_wdata(memWdata), .mem_wmask(memWmask),
    .mem_rsp_valid(memRspValid), .mem_rdata(memRdata)
  );

  // Pure-LSU-priority instance sharing every input with the main one.
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(0), .TIMEOUT_CYCLES(TO)) dutNoStarve (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifuReqValid), .ifu_req_ready(nIfuReqReady), .ifu_addr(ifuAddr),
    .ifu_rsp_valid(nIfuRspValid), .ifu_rsp_err(nIfuRspErr), .ifu_rdata(nIfuRdata),
    .lsu_req_valid(lsuReqValid), .lsu_req_ready(nLsuReqReady), .lsu_addr(lsuAddr),
    .lsu_wen(lsuWen), .lsu_wdata(lsuWdata), .lsu_wmask(lsuWmask),
    .lsu_rsp_valid(nLsuRspValid), .lsu_rsp_err(nLsuRspErr), .lsu_rdata(nLsuRdata),
    .mem_req_valid(nMemReqValid), .mem_req_ready(memReqReady), .mem_addr(nMemAddr),
    .mem_wen(nMemWen), .mem_wdata(nMemWdata), .mem_wmask(nMemWmask),
    .mem_rsp_valid(memRspValid), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit            haveTxn, accepted, respPending, expErr, txnIfu;
  logic [AW-1:0] txnAddr;
  logic          txnWen;
  logic [DW-1:0] txnWdata, lastIfuRdata, lastLsuRdata;
  logic [7:0]    txnWmask;
  int            starveRun, waitCycles, errPulses;
  bit            sawIfuGrant, sawLsuGrant, sawNIfuGrant, sawNLsuGrant;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    haveTxn      = 1'b0;
    accepted     = 1'b0;
    respPending  = 1'b0;
    expErr       = 1'b0;
    starveRun    = 0;
    waitCycles   = 0;
    lastIfuRdata = '0;
    lastLsuRdata = '0;
  endtask

  // Called at posedge+1 with this cycle's inputs already driven; checks, advances the model, returns at the next posedge+1.
  task automatic applyStimulus();
    bit expLsuGrant, expIfuGrant, expMemValid;
    #1;
    expLsuGrant = 1'b0;
    expIfuGrant = 1'b0;
    if (!rst && !haveTxn) begin
      expLsuGrant = lsuReqValid && !(ifuReqValid && (LIM != 0) && (starveRun == LIM));
      expIfuGrant = ifuReqValid && !expLsuGrant;
    end
    checkOutput("lsu_req_ready", lsuReqReady, expLsuGrant);
    checkOutput("ifu_req_ready", ifuReqReady, expIfuGrant);
    sawIfuGrant  = ifuReqReady;
    sawLsuGrant  = lsuReqReady;
    sawNIfuGrant = nIfuReqReady;
    sawNLsuGrant = nLsuReqReady;

    expMemValid = haveTxn && !accepted;
    checkOutput("mem_req_valid", memReqValid, expMemValid);
    if (expMemValid) begin
      checkOutput("mem_addr", memAddr, txnAddr);
      checkOutput("mem_wen", memWen, txnWen);
      checkOutput("mem_wmask", memWmask, txnWmask);
      if (!txnIfu) checkOutput("mem_wdata", memWdata, txnWdata);
    end
    checkOutput("ifu_rsp_valid", ifuRspValid, respPending && txnIfu);
    checkOutput("lsu_rsp_valid", lsuRspValid, respPending && !txnIfu);
    checkOutput("ifu_rsp_err", ifuRspErr, respPending && txnIfu && expErr);
    checkOutput("lsu_rsp_err", lsuRspErr, respPending && !txnIfu && expErr);
    checkOutput("ifu_rdata", ifuRdata, lastIfuRdata);
    checkOutput("lsu_rdata", lsuRdata, lastLsuRdata);
    if (lsuRspErr === 1'b1 || ifuRspErr === 1'b1) errPulses++;

    if (rst) begin
      modelReset();
    end else if (respPending) begin
      haveTxn     = 1'b0;
      respPending = 1'b0;
      expErr      = 1'b0;
    end else if (haveTxn && !accepted) begin
      if (memReqReady) begin
        accepted   = 1'b1;
        waitCycles = 0;
      end
    end else if (haveTxn) begin
      if (memRspValid) begin
        respPending = 1'b1;
        expErr      = 1'b0;
        if (txnIfu) lastIfuRdata = memRdata;
        else        lastLsuRdata = memRdata;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else begin
        waitCycles++;
        if (waitCycles == TO) begin
          respPending = 1'b1;
          expErr      = 1'b1;
          if (txnIfu) lastIfuRdata = '0;
          else        lastLsuRdata = '0;
        end
      end
`endif
    end else if (expLsuGrant || expIfuGrant) begin
      haveTxn  = 1'b1;
      accepted = 1'b0;
      txnIfu   = expIfuGrant;
      if (expIfuGrant) begin
        txnAddr   = ifuAddr;
        txnWen    = 1'b0;
        txnWdata  = '0;
        txnWmask  = 8'h00;
        starveRun = 0;
      end else begin
        txnAddr  = lsuAddr;
        txnWen   = lsuWen;
        txnWdata = lsuWdata;
        txnWmask = lsuWmask;
        if (ifuReqValid && starveRun < LIM) starveRun++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;
    int nLsuGrants;
    modelReset();
    errPulses = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ifu_req_ready", ifuReqReady, 0);
    checkOutput("reset lsu_req_ready", lsuReqReady, 0);
    checkOutput("reset mem_req_valid", memReqValid, 0);
    checkOutput("reset mem_addr", memAddr, 0);
    checkOutput("reset mem_wen", memWen, 0);
    checkOutput("reset mem_wdata", memWdata, 0);
    checkOutput("reset mem_wmask", memWmask, 0);
    checkOutput("reset ifu_rsp_valid", ifuRspValid, 0);
    checkOutput("reset lsu_rsp_valid", lsuRspValid, 0);
    checkOutput("reset ifu_rsp_err", ifuRspErr, 0);
    checkOutput("reset lsu_rsp_err", lsuRspErr, 0);
    checkOutput("reset ifu_rdata", ifuRdata, 0);
    checkOutput("reset lsu_rdata", lsuRdata, 0);
    checkOutput("reset n ready", {nIfuReqReady, nLsuReqReady, nMemReqValid, nMemWen}, 0);
    checkOutput("reset n rsp", {nIfuRspValid, nLsuRspValid, nIfuRspErr, nLsuRspErr}, 0);
    checkOutput("reset n payload", nMemAddr | nMemWdata | {56'd0, nMemWmask}, 0);
    checkOutput("reset n rdata", nIfuRdata | nLsuRdata, 0);
    rst = 1'b0;

    // IFU-only fetch with an immediately ready memory.
    ifuReqValid = 1'b1; ifuAddr = 64'h8000_0000; memReqReady = 1'b1; memRspValid = 1'b0;
    applyStimulus();
    ifuReqValid = 1'b0;
    applyStimulus();
    memRspValid = 1'b1; memRdata = 64'h0010_0073;
    applyStimulus();
    memRspValid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("ifu fetch rdata held", ifuRdata, 64'h0010_0073);

    // LSU store with three stalled memory cycles; requester inputs change after the grant.
    lsuReqValid = 1'b1; lsuAddr = 64'h8000_1000; lsuWen = 1'b1; lsuWdata = 64'hDEAD_BEEF;
    lsuWmask = 8'h0F; memReqReady = 1'b0;
    applyStimulus();
    lsuReqValid = 1'b0; lsuAddr = '0; lsuWdata = '0; lsuWmask = 8'h00; lsuWen = 1'b0;
    repeat (3) applyStimulus();
    memReqReady = 1'b1;
    applyStimulus();
    memRspValid = 1'b1; memRdata = 64'h0000_1234;
    applyStimulus();
    memRspValid = 1'b0;
    applyStimulus();
    applyStimulus();

    // Both requesters always valid: 4 LSU grants then one IFU; the no-starve instance never serves the IFU.
    ifuReqValid = 1'b1; lsuReqValid = 1'b1; memReqReady = 1'b1; memRspValid = 1'b1;
    grants = 0;
    nLsuGrants = 0;
    for (int cyc = 0; cyc < 400 && grants < 50; cyc++) begin
      ifuAddr  = {$urandom, $urandom};
      lsuAddr  = {$urandom, $urandom};
      lsuWdata = {$urandom, $urandom};
      memRdata = {$urandom, $urandom};
      applyStimulus();
      checkOutput("nostarve ifu_req_ready", sawNIfuGrant, 0);
      if (sawNLsuGrant) nLsuGrants++;
      if (sawIfuGrant || sawLsuGrant) begin
        if (grants < 10) checkOutput("starve grant order", sawIfuGrant, (grants % 5) == 4);
        grants++;
      end
    end
    checkOutput("starve grant count", grants, 50);
    checkOutput("nostarve lsu grant count", nLsuGrants, 50);
    ifuReqValid = 1'b0; lsuReqValid = 1'b0;
    repeat (4) applyStimulus();
    memRspValid = 1'b0;
    applyStimulus();

    // Reset while waiting for memory: no response, late memory data ignored, then a clean fetch.
    ifuReqValid = 1'b1; ifuAddr = 64'h8000_0040;
    applyStimulus();
    ifuReqValid = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0; memRspValid = 1'b1; memRdata = 64'h0000_0BAD;
    repeat (2) applyStimulus();
    memRspValid = 1'b0; ifuReqValid = 1'b1; ifuAddr = 64'h8000_0080;
    applyStimulus();
    ifuReqValid = 1'b0;
    applyStimulus();
    memRspValid = 1'b1; memRdata = 64'h0000_0013;
    applyStimulus();
    memRspValid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("post-reset fetch rdata", ifuRdata, 64'h0000_0013);

    // Memory never answers a load for 20 cycles, then answers late.
    errPulses = 0;
    lsuReqValid = 1'b1; lsuAddr = 64'h8000_2000; lsuWen = 1'b0; lsuWmask = 8'hFF;
    applyStimulus();
    lsuReqValid = 1'b0;
    repeat (20) applyStimulus();
    memRspValid = 1'b1; memRdata = 64'h0000_0777;
    applyStimulus();
    memRspValid = 1'b0;
    repeat (3) applyStimulus();
`ifdef MEM_ARB_TIMEOUT_EN
    checkOutput("timeout err pulses", errPulses, 1);
`else
    checkOutput("timeout err pulses", errPulses, 0);
`endif

    // Randomized traffic with stalls, dropped requests and delayed responses.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (sawIfuGrant) ifuReqValid = 1'b0;
      else if (ifuReqValid) begin
        if ($urandom_range(0, 7) == 0) ifuReqValid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        ifuReqValid = 1'b1;
        ifuAddr     = {$urandom, $urandom};
      end
      if (sawLsuGrant) lsuReqValid = 1'b0;
      else if (lsuReqValid) begin
        if ($urandom_range(0, 7) == 0) lsuReqValid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        lsuReqValid = 1'b1;
        lsuAddr     = {$urandom, $urandom};
        lsuWen      = 1'($urandom_range(0, 1));
        lsuWdata    = {$urandom, $urandom};
        lsuWmask    = 8'($urandom);
      end
      memReqReady = ($urandom_range(0, 2) != 0);
      memRspValid = ($urandom_range(0, 2) == 0);
      memRdata    = {$urandom, $urandom};
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Replaces the two direct rom/ram hookups once the core moves to a multi-cycle or pipelined fetch.
- Grants one transaction at a time: fixed LSU priority with an IFU starvation guard.
- Sequences issue, wait and response, then routes read data back to the owning requester.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_LIMIT, 4, max consecutive LSU wins while the IFU waits; 0 = pure LSU priority.
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  one-cycle pulse, fetch data valid.
- ifu_rsp_err  out  1  qualifies ifu_rsp_valid.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  data address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  8  byte strobes.
- lsu_rsp_valid  out  1  one-cycle pulse, load data or store done.
- lsu_rsp_err  out  1  qualifies lsu_rsp_valid.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_addr  out  ADDR_W  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  8  memory byte strobes; 0 for IFU.
- mem_rsp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock port is clk; reset port is rst, synchronous active-high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE, owner=LSU, starve_cnt=0. All valid/ready/err outputs are 0; rdata and mem_* payload registers are 0.
- IDLE arbitration (combinational):
  - Winner is LSU if lsu_req_valid and not (ifu_req_valid and starve_cnt==STARVE_LIMIT and STARVE_LIMIT!=0).
  - Otherwise winner is IFU if ifu_req_valid.
  - Only the winner's req_ready=1; both ready=0 outside IDLE.
- Handshake (valid and ready):
  - Latch addr, wen, wdata and wmask into registers; IFU requests latch wen=0, wmask=0.
  - Record owner; go to ISSUE.
- starve_cnt:
  - +1 on each LSU grant while ifu_req_valid=1, saturating at STARVE_LIMIT.
  - Cleared on an IFU grant.
  - Unchanged otherwise.
- ISSUE: mem_req_valid=1 with the latched payload, which stays stable. On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid, capture mem_rdata into the owner's rdata register, clear err, go to RESP.
  - mem_rsp_valid outside WAIT is ignored.
- RESP: owner's rsp_valid=1 for exactly one cycle, then IDLE.
  - A new grant occurs no earlier than the IDLE cycle that follows.
  - rdata holds its value until the next response to that requester.
- Minimum latency, request handshake to rsp_valid: 3 cycles (ISSUE and WAIT one cycle each).
- Throughput: 1 transaction per 4 cycles at best.
- Store responses: lsu_rsp_valid still pulses; lsu_rdata = captured mem_rdata (don't-care content).
- Simultaneous requests from both requesters at reset exit: LSU wins; IFU waits.
- Requester valid dropping before ready: no grant; no error.
- rst asserted in any state:
  - Next cycle is IDLE; the in-flight transaction is abandoned; no rsp pulse.
  - starve_cnt=0.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_rsp_valid: go to RESP with owner's rsp_err=1 and rdata=0.
  - A late mem_rsp_valid is then ignored.
- Undefined: no counter; WAIT lasts indefinitely; both rsp_err outputs tied 0.

Test Plan:
- IFU only: addr 0x80000000, mem_req_ready=1 immediately, mem_rsp_valid one cycle later with 0x00100073 -> ifu_rsp_valid 3 cycles after handshake; ifu_rdata=0x00100073; lsu_rsp_valid stays 0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem_wen=1, mem_wmask=0x0F, payload stable across 3 stalled mem_req_ready cycles; lsu_rsp_valid pulses once.
- Both valid continuously, STARVE_LIMIT=4 -> grant order LSU, LSU, LSU, LSU, IFU, then repeats; ifu_req_ready never high while LSU is in a run under the limit.
- STARVE_LIMIT=0 with both always valid -> IFU never granted in 50 transactions.
- rst asserted for 1 cycle in WAIT -> next cycle state IDLE, no rsp pulse; a later mem_rsp_valid is ignored; a fresh IFU request then completes normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, no mem_rsp_valid -> rsp_valid and rsp_err=1 with rdata=0 after 8 WAIT cycles. Without the macro, the same stimulus stays in WAIT and rsp_err stays 0.
